multicycle_ctrl: RTL

- Multi-cycle sequencing controller for the MIPS datapath (PC, IM, IR, GRF, EXT, ALU, DM, NPC).
- Replaces the single-cycle combinational Controller with a Moore/Mealy FSM. The FSM issues per-cycle write enables and mux selects, waits on a data-memory ready handshake, and counts retired instructions.
- Sits beside the datapath. It reads op/func from the datapath instruction register (IR) and zero from the ALU.

---
 rtl/mips_ctrl_pkg.sv | 70 +++++++
 rtl/insn_decode.sv | 34 +++
 rtl/multicycle_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states,
// opcode/func fields, mux-select codes and the decoded instruction class.
package mips_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNC_W  = 6;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned NPCOP_W = 3;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXE    = 4'd2,
    ST_MEM_RD = 4'd3,
    ST_MEM_WR = 4'd4,
    ST_WB_ALU = 4'd5,
    ST_WB_MEM = 4'd6,
    ST_BRANCH = 4'd7,
    ST_JUMP   = 4'd8
  } state_e;

  localparam logic [OP_W-1:0] OP_SPECIAL = 6'b000000;
  localparam logic [OP_W-1:0] OP_ORI     = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI     = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW      = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW      = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ     = 6'b000100;
  localparam logic [OP_W-1:0] OP_JAL     = 6'b000011;

  localparam logic [FUNC_W-1:0] FN_ADDU = 6'b100001;
  localparam logic [FUNC_W-1:0] FN_SUBU = 6'b100011;
  localparam logic [FUNC_W-1:0] FN_JR   = 6'b001000;
  localparam logic [FUNC_W-1:0] FN_NOP  = 6'b000000;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'd2;
  localparam logic [ALUOP_W-1:0] ALU_LUI = 3'd3;

  localparam logic [NPCOP_W-1:0] NPC_PC4 = 3'd0;
  localparam logic [NPCOP_W-1:0] NPC_BEQ = 3'd1;
  localparam logic [NPCOP_W-1:0] NPC_JAL = 3'd2;
  localparam logic [NPCOP_W-1:0] NPC_JR  = 3'd3;

  localparam logic [SEL_W-1:0] WD_ALU = 2'd0;
  localparam logic [SEL_W-1:0] WD_DM  = 2'd1;
  localparam logic [SEL_W-1:0] WD_PC4 = 2'd2;

  localparam logic [SEL_W-1:0] A3_RT = 2'd0;
  localparam logic [SEL_W-1:0] A3_RD = 2'd1;
  localparam logic [SEL_W-1:0] A3_RA = 2'd2;

  // One-hot instruction class; exactly one bit set for any op/func.
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic nop;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic jal;
    logic illegal;
  } insn_class_t;

endpackage

// File: rtl/insn_decode.sv
// Combinational instruction classifier: IR op/func -> one-hot class.
// Ports: op_i/func_i from IR, cls_c_o one-hot class (combinational).
module insn_decode
  import mips_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  input  logic [FUNC_W-1:0] func_i,
  output insn_class_t       cls_c_o
);

  always_comb begin
    cls_c_o = '0;
    if (op_i == OP_SPECIAL) begin
      case (func_i)
        FN_ADDU: cls_c_o.addu    = 1'b1;
        FN_SUBU: cls_c_o.subu    = 1'b1;
        FN_JR:   cls_c_o.jr      = 1'b1;
        FN_NOP:  cls_c_o.nop     = 1'b1;
        default: cls_c_o.illegal = 1'b1;
      endcase
    end else begin
      case (op_i)
        OP_ORI:  cls_c_o.ori     = 1'b1;
        OP_LUI:  cls_c_o.lui     = 1'b1;
        OP_LW:   cls_c_o.lw      = 1'b1;
        OP_SW:   cls_c_o.sw      = 1'b1;
        OP_BEQ:  cls_c_o.beq     = 1'b1;
        OP_JAL:  cls_c_o.jal     = 1'b1;
        default: cls_c_o.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencing controller. Steps FETCH/DECODE/EXE/MEM/WB
// states, drives datapath write enables and mux selects (combinational from
// state, op, func, zero), waits on dm_ready in MEM states and counts retired
// instructions.
// Ports: clk/reset (sync, active-high); op/func from IR; zero from ALU;
// dm_ready DM handshake; PCWr/IRWr/RFWr/DMWr/dm_req enables; EXTOp, ALUBSel,
// ALUOp, RFWDSel, RFA3Sel, NPCOp selects; state (debug); instr_done pulse;
// instr_cnt retired count.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNC_W-1:0]  func,
  input  logic               zero,
  input  logic               dm_ready,
  output logic               PCWr,
  output logic               IRWr,
  output logic               RFWr,
  output logic               DMWr,
  output logic               dm_req,
  output logic               EXTOp,
  output logic               ALUBSel,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [SEL_W-1:0]   RFWDSel,
  output logic [SEL_W-1:0]   RFA3Sel,
  output logic [NPCOP_W-1:0] NPCOp,
  output logic [STATE_W-1:0] state,
  output logic               instr_done,
  output logic [CNT_W-1:0]   instr_cnt
);

  state_e           state_q, state_d;
  insn_class_t      cls_c;
  logic [CNT_W-1:0] instr_cnt_q;

  logic               pc_wr_c, ir_wr_c, rf_wr_c, dm_wr_c, dm_req_c, done_c;
  logic               ext_op_c, alub_sel_c;
  logic [ALUOP_W-1:0] alu_op_c;
  logic [SEL_W-1:0]   rfwd_sel_c, rfa3_sel_c;
  logic [NPCOP_W-1:0] npc_op_c;

  logic               exe_ext_op_c, exe_alub_sel_c;
  logic [ALUOP_W-1:0] exe_alu_op_c;

  insn_decode u_decode (
    .op_i    (op),
    .func_i  (func),
    .cls_c_o (cls_c)
  );

  // ALU selects set up in EXE and held through the MEM/WB_ALU cycles.
  always_comb begin
    exe_alu_op_c   = ALU_ADD;
    exe_alub_sel_c = 1'b0;
    exe_ext_op_c   = 1'b0;
    if (cls_c.subu) begin
      exe_alu_op_c = ALU_SUB;
    end else if (cls_c.ori) begin
      exe_alu_op_c   = ALU_OR;
      exe_alub_sel_c = 1'b1;
    end else if (cls_c.lui) begin
      exe_alu_op_c   = ALU_LUI;
      exe_alub_sel_c = 1'b1;
    end else if (cls_c.lw || cls_c.sw) begin
      exe_alub_sel_c = 1'b1;
      exe_ext_op_c   = 1'b1;
    end
  end

  // Next-state and per-state outputs.
  always_comb begin
    state_d    = state_q;
    pc_wr_c    = 1'b0;
    ir_wr_c    = 1'b0;
    rf_wr_c    = 1'b0;
    dm_wr_c    = 1'b0;
    dm_req_c   = 1'b0;
    done_c     = 1'b0;
    ext_op_c   = 1'b0;
    alub_sel_c = 1'b0;
    alu_op_c   = ALU_ADD;
    rfwd_sel_c = WD_ALU;
    rfa3_sel_c = A3_RT;
    npc_op_c   = NPC_PC4;
    case (state_q)
      ST_FETCH: begin
        ir_wr_c  = 1'b1;
        pc_wr_c  = 1'b1;
        npc_op_c = NPC_PC4;
        state_d  = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = ST_FETCH;
        if (cls_c.addu || cls_c.subu || cls_c.ori || cls_c.lui ||
            cls_c.lw || cls_c.sw) begin
          state_d = ST_EXE;
        end else if (cls_c.beq) begin
          state_d = ST_BRANCH;
        end else if (cls_c.jal || cls_c.jr) begin
          state_d = ST_JUMP;
        end else if (cls_c.nop || cls_c.illegal) begin
          done_c = 1'b1;
        end
      end
      ST_EXE: begin
        alu_op_c   = exe_alu_op_c;
        alub_sel_c = exe_alub_sel_c;
        ext_op_c   = exe_ext_op_c;
        if (cls_c.lw) begin
          state_d = ST_MEM_RD;
        end else if (cls_c.sw) begin
          state_d = ST_MEM_WR;
        end else begin
          state_d = ST_WB_ALU;
        end
      end
      ST_MEM_RD: begin
        alu_op_c   = exe_alu_op_c;
        alub_sel_c = exe_alub_sel_c;
        ext_op_c   = exe_ext_op_c;
        dm_req_c   = 1'b1;
        if (dm_ready) state_d = ST_WB_MEM;
      end
      ST_MEM_WR: begin
        alu_op_c   = exe_alu_op_c;
        alub_sel_c = exe_alub_sel_c;
        ext_op_c   = exe_ext_op_c;
        dm_req_c   = 1'b1;
        dm_wr_c    = 1'b1;
        if (dm_ready) begin
          done_c  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_WB_ALU: begin
        alu_op_c   = exe_alu_op_c;
        alub_sel_c = exe_alub_sel_c;
        ext_op_c   = exe_ext_op_c;
        rf_wr_c    = 1'b1;
        rfwd_sel_c = WD_ALU;
        rfa3_sel_c = (cls_c.addu || cls_c.subu) ? A3_RD : A3_RT;
        done_c     = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_WB_MEM: begin
        rf_wr_c    = 1'b1;
        rfwd_sel_c = WD_DM;
        rfa3_sel_c = A3_RT;
        done_c     = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_op_c = ALU_SUB;
        npc_op_c = NPC_BEQ;
        pc_wr_c  = zero;
        done_c   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_JUMP: begin
        if (cls_c.jal) begin
          npc_op_c   = NPC_JAL;
          pc_wr_c    = 1'b1;
          rf_wr_c    = 1'b1;
          rfa3_sel_c = A3_RA;
          rfwd_sel_c = WD_PC4;
        end else if (cls_c.jr) begin
          npc_op_c   = NPC_JR;
          pc_wr_c    = 1'b1;
          alu_op_c   = ALU_ADD;
          alub_sel_c = 1'b0;
        end
        done_c  = 1'b1;
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // State and retired-instruction counter; reset aborts without counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      instr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (done_c) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
    end
  end

  // Write enables and the done pulse are suppressed during reset.
  assign PCWr       = pc_wr_c  & ~reset;
  assign IRWr       = ir_wr_c  & ~reset;
  assign RFWr       = rf_wr_c  & ~reset;
  assign DMWr       = dm_wr_c  & ~reset;
  assign dm_req     = dm_req_c & ~reset;
  assign instr_done = done_c   & ~reset;
  assign EXTOp      = ext_op_c;
  assign ALUBSel    = alub_sel_c;
  assign ALUOp      = alu_op_c;
  assign RFWDSel    = rfwd_sel_c;
  assign RFA3Sel    = rfa3_sel_c;
  assign NPCOp      = npc_op_c;
  assign state      = state_q;
  assign instr_cnt  = instr_cnt_q;

endmodule
